// File: rtl/byte_accumulator.sv
// ---------------------------------------------------------------------------
// byte_accumulator
//   Sums each batch of COUNT 8-bit operands received over a valid/ready
//   input port and presents the 16-bit total on a valid/ready output port.
//   The low byte of the running sum goes through an 8-bit ripple adder
//   (submod). Its carry-out increments the high byte.
//
// Ports
//   clk        in   1   clock, all state updates on the rising edge
//   rst        in   1   asynchronous active-high reset
//   clear      in   1   synchronous batch abort (ignored while a total is held)
//   in_valid   in   1   in_data holds an operand
//   in_ready   out  1   an operand can be accepted this cycle
//   in_data    in   8   operand
//   out_valid  out  1   out_sum holds a completed batch total
//   out_ready  in   1   consumer takes out_sum this cycle
//   out_sum    out  16  batch total {hi, lo}
//   busy       out  1   batch started and not yet delivered
//
// All outputs come straight from flops. There is no combinational path from
// in_valid or out_ready to any output.
// ---------------------------------------------------------------------------

// 8-bit ripple-carry adder: out = a + b + c
module submod (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c,
  output logic [8:0] out
);

  // Bit-serial full-adder chain
  always_comb begin
    logic carry;
    carry = c;
    out   = 9'h000;
    for (int i = 0; i < 8; i++) begin
      out[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (a[i] & carry) | (b[i] & carry);
    end
    out[8] = carry;
  end

endmodule

module byte_accumulator #(
  parameter int unsigned COUNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic        busy
);

  localparam int unsigned CW = (COUNT < 2) ? 1 : $clog2(COUNT + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(COUNT - 1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    lo_q, lo_d;
  logic [7:0]    hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [15:0]   out_sum_q, out_sum_d;
  logic          busy_q, busy_d;

  logic [8:0]    sum9;
  logic          accept;

  submod u_add (
    .a   (lo_q),
    .b   (in_data),
    .c   (1'b0),
    .out (sum9)
  );

  // in_ready_q is high only in ACC, so this already excludes the HOLD cycle
  assign accept = in_valid & in_ready_q;

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    busy_d      = busy_q;

    case (state_q)
      ACC: begin
        if (clear) begin
          // clear wins over a simultaneous operand
          lo_d   = 8'h00;
          hi_d   = 8'h00;
          cnt_d  = {CW{1'b0}};
          busy_d = 1'b0;
        end else if (accept) begin
          lo_d   = sum9[7:0];
          hi_d   = hi_q + {7'h00, sum9[8]};
          cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
          busy_d = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d     = HOLD;
            in_ready_d  = 1'b0;
            out_valid_d = 1'b1;
            out_sum_d   = {hi_d, lo_d};
          end else begin
            state_d = ACC;
          end
        end else begin
          state_d = ACC;
        end
      end

      HOLD: begin
        // The total stays put until taken; clear cannot discard it
        if (out_ready) begin
          state_d     = ACC;
          lo_d        = 8'h00;
          hi_d        = 8'h00;
          cnt_d       = {CW{1'b0}};
          in_ready_d  = 1'b1;
          out_valid_d = 1'b0;
          out_sum_d   = 16'h0000;
          busy_d      = 1'b0;
        end else begin
          state_d = HOLD;
        end
      end

      default: begin
        state_d     = ACC;
        lo_d        = 8'h00;
        hi_d        = 8'h00;
        cnt_d       = {CW{1'b0}};
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
        out_sum_d   = 16'h0000;
        busy_d      = 1'b0;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ACC;
      lo_q        <= 8'h00;
      hi_q        <= 8'h00;
      cnt_q       <= {CW{1'b0}};
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= 16'h0000;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_byte_accumulator.sv
// ---------------------------------------------------------------------------
// tb_byte_accumulator
//   Three instances (COUNT = 4, 256, 1) are driven by directed and random
//   traffic. A batch-level model tracks how many operands have been taken
//   and their arithmetic sum. A compare process checks every DUT output
//   against that model on each falling edge. Literal checks pin the totals
//   for the hand-worked sequences.
// ---------------------------------------------------------------------------
module tb_byte_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [2:0]       in_valid  = 3'b000;
  logic [2:0]       clear     = 3'b000;
  logic [2:0]       out_ready = 3'b000;
  logic [2:0][7:0]  in_data   = '0;
  logic [2:0]       in_ready;
  logic [2:0]       out_valid;
  logic [2:0]       busy;
  logic [2:0][15:0] out_sum;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  byte_accumulator #(.COUNT(4)) dut4 (
    .clk(clk), .rst(rst), .clear(clear[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .in_data(in_data[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_sum(out_sum[0]), .busy(busy[0])
  );

  byte_accumulator #(.COUNT(256)) dut256 (
    .clk(clk), .rst(rst), .clear(clear[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .in_data(in_data[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_sum(out_sum[1]), .busy(busy[1])
  );

  byte_accumulator #(.COUNT(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .in_data(in_data[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_sum(out_sum[2]), .busy(busy[2])
  );

  // Batch model: operands taken so far, their sum, and whether a total waits
  int cnt_of [3] = '{4, 256, 1};
  int m_sum  [3] = '{0, 0, 0};
  int m_n    [3] = '{0, 0, 0};
  bit m_hold [3] = '{1'b0, 1'b0, 1'b0};

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_sum[k]  <= 0;
        m_n[k]    <= 0;
        m_hold[k] <= 1'b0;
      end else if (m_hold[k]) begin
        if (out_ready[k]) begin
          m_sum[k]  <= 0;
          m_n[k]    <= 0;
          m_hold[k] <= 1'b0;
        end
      end else if (clear[k]) begin
        m_sum[k] <= 0;
        m_n[k]   <= 0;
      end else if (in_valid[k]) begin
        m_sum[k]  <= m_sum[k] + int'(in_data[k]);
        m_n[k]    <= m_n[k] + 1;
        m_hold[k] <= (m_n[k] + 1 == cnt_of[k]);
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk("in_ready", k, 32'(in_ready[k]), 32'(!m_hold[k]));
      chk("out_valid", k, 32'(out_valid[k]), 32'(m_hold[k]));
      chk("busy", k, 32'(busy[k]), 32'((m_n[k] != 0) || m_hold[k]));
      if (m_hold[k]) chk("out_sum", k, 32'(out_sum[k]), m_sum[k]);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_outs(input int k);
    chk("idle_in_ready", k, 32'(in_ready[k]), 32'd1);
    chk("idle_out_valid", k, 32'(out_valid[k]), 32'd0);
    chk("idle_out_sum", k, 32'(out_sum[k]), 32'h0000);
    chk("idle_busy", k, 32'(busy[k]), 32'd0);
  endtask

  logic [7:0] ops [4] = '{8'h10, 8'h20, 8'h30, 8'h40};

  initial begin
    int acc;
    int guard;
    bit v;

    // Reset then idle
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) idle_outs(k);
    rst = 1'b0;
    cyc();
    for (int k = 0; k < 3; k++) idle_outs(k);

    // 10,20,30,40 back-to-back, consumer always ready
    out_ready[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = ops[i];
      cyc();
    end
    in_valid[0] = 1'b0;
    chk("sum_a0_valid", 0, 32'(out_valid[0]), 32'd1);
    chk("sum_a0", 0, 32'(out_sum[0]), 32'h00A0);
    cyc();
    chk("a0_valid_drop", 0, 32'(out_valid[0]), 32'd0);
    chk("a0_ready_back", 0, 32'(in_ready[0]), 32'd1);

    // Four FF with the consumer stalled for 5 cycles
    out_ready[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'hFF;
      cyc();
    end
    in_valid[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("hold_3fc", 0, 32'(out_sum[0]), 32'h03FC);
      chk("hold_valid", 0, 32'(out_valid[0]), 32'd1);
      chk("hold_not_ready", 0, 32'(in_ready[0]), 32'd0);
      cyc();
    end
    out_ready[0] = 1'b1;
    cyc();
    out_ready[0] = 1'b0;
    idle_outs(0);

    // Operand offered in the handshake cycle must wait a cycle
    for (int i = 0; i < 4; i++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = 8'h01;
      cyc();
    end
    out_ready[0] = 1'b1;
    in_data[0]   = 8'h05;
    cyc();
    out_ready[0] = 1'b0;
    chk("collide_not_taken", 0, 32'(busy[0]), 32'd0);
    cyc();
    chk("collide_taken", 0, 32'(busy[0]), 32'd1);
    in_data[0] = 8'h00;
    repeat (3) cyc();
    in_valid[0] = 1'b0;
    chk("collide_sum", 0, 32'(out_sum[0]), 32'h0005);
    out_ready[0] = 1'b1;
    cyc();

    // clear after 80,80 with an operand in the same cycle
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = 8'h80;
    repeat (2) cyc();
    clear[0]   = 1'b1;
    in_data[0] = 8'h77;
    cyc();
    clear[0] = 1'b0;
    chk("clear_busy", 0, 32'(busy[0]), 32'd0);
    in_data[0] = 8'h01;
    repeat (4) cyc();
    in_valid[0] = 1'b0;
    chk("clear_then_4", 0, 32'(out_sum[0]), 32'h0004);
    out_ready[0] = 1'b1;
    cyc();

    // Reset in the middle of a batch
    in_valid[0] = 1'b1;
    in_data[0]  = 8'h33;
    repeat (2) cyc();
    in_valid[0] = 1'b0;
    rst = 1'b1;
    #1;
    idle_outs(0);
    cyc();
    idle_outs(0);
    rst = 1'b0;
    cyc();
    idle_outs(0);

    // COUNT = 1 passes each operand straight through
    out_ready[2] = 1'b0;
    in_valid[2]  = 1'b1;
    in_data[2]   = 8'hA5;
    cyc();
    in_valid[2] = 1'b0;
    chk("count1_sum", 2, 32'(out_sum[2]), 32'h00A5);
    out_ready[2] = 1'b1;
    cyc();

    // COUNT = 256 of FF with random gaps
    out_ready[1] = 1'b0;
    acc   = 0;
    guard = 0;
    while (acc < 256 && guard < 3000) begin
      v = ($urandom_range(0, 2) != 0);
      in_valid[1] = v;
      in_data[1]  = 8'hFF;
      if (v && in_ready[1]) acc++;
      cyc();
      guard++;
    end
    in_valid[1] = 1'b0;
    chk("c256_accepts", 1, acc, 32'd256);
    chk("c256_valid", 1, 32'(out_valid[1]), 32'd1);
    chk("c256_sum", 1, 32'(out_sum[1]), 32'hFF00);
    out_ready[1] = 1'b1;
    cyc();
    out_ready[1] = 1'b0;
    chk("c256_done", 1, 32'(out_valid[1]), 32'd0);

    // Random traffic on COUNT = 4 and COUNT = 1
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < 3; k += 2) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        in_data[k]   = 8'($urandom);
        clear[k]     = ($urandom_range(0, 15) == 0);
        out_ready[k] = ($urandom_range(0, 1) != 0);
      end
      cyc();
    end
    in_valid  = 3'b000;
    clear     = 3'b000;
    out_ready = 3'b000;
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
